aes_stream_ctrl: RTL

//  Admission/sequencing controller for the free-running pipelined AES encoder (no stall input).

---
 rtl/aes_stream_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: feeds two round-robin requesters into a free-running AES pipeline and buffers results in a credit-guarded FIFO.
// Define AES_STREAM_CTRL_PERF_EN to add perf_blocks/perf_stall/perf_keys counters.
module aes_stream_ctrl #(
   parameter int LATENCY    = 11,
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 128,
   parameter int KEY_W      = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [KEY_W-1:0]  key_in,
   output logic [DATA_W-1:0] enc_in,
   output logic [KEY_W-1:0]  enc_key,
   input  logic [DATA_W-1:0] enc_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
`ifdef AES_STREAM_CTRL_PERF_EN
   output logic              busy,
   output logic [31:0]       perf_blocks,
   output logic [31:0]       perf_stall,
   output logic [15:0]       perf_keys
`else
   output logic              busy
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               rr_q, rr_d;
   logic [LATENCY-1:0] tag_v_q, tag_v_d, tag_s_q, tag_s_d;
   logic [CW-1:0]      infl_q, infl_d, cnt_q, cnt_d;
   logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [DATA_W:0]    mem_q [FIFO_DEPTH];
   logic               allow, g0, g1, push, pop, kload;

   // Credit counts blocks still inside the pipeline as already occupying FIFO space.
   always_comb begin
      allow   = reset && state_q == RUN && ({1'b0, infl_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH);
      g0      = allow && req0_valid && (!req1_valid || !rr_q);
      g1      = allow && req1_valid && (!req0_valid || rr_q);
      push    = tag_v_q[LATENCY-1];
      pop     = cnt_q != '0 && out_ready;
      kload   = state_q == DRAIN && infl_q == '0;
      rr_d    = g0 ? 1'b1 : g1 ? 1'b0 : rr_q;
      tag_v_d = {tag_v_q[LATENCY-2:0], g0 | g1};
      tag_s_d = {tag_s_q[LATENCY-2:0], g1};
      infl_d  = infl_q + CW'(g0 | g1) - CW'(push);
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      wr_d    = push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = pop ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
      state_d = state_q == RUN ? (key_valid ? DRAIN : RUN) : state_q == DRAIN ? (kload ? LOAD : DRAIN) : RUN;
      key_d   = kload ? key_in : key_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         rr_q    <= 1'b0;
         tag_v_q <= '0;
         tag_s_q <= '0;
         infl_q  <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         tag_v_q <= tag_v_d;
         tag_s_q <= tag_s_d;
         infl_q  <= infl_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         key_q   <= key_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= {enc_out, tag_s_q[LATENCY-1]};
   end

   always_ff @(posedge clock) begin
      if (reset) assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
   end

   assign req0_ready = g0;
   assign req1_ready = g1;
   assign enc_in     = g0 ? req0_data : g1 ? req1_data : '0;
   assign enc_key    = key_q;
   assign out_valid  = cnt_q != '0;
   assign out_data   = out_valid ? mem_q[rd_q][DATA_W:1] : '0;
   assign out_src    = out_valid & mem_q[rd_q][0];
   assign key_ready  = state_q == LOAD;
   assign busy       = state_q != RUN || infl_q != '0 || cnt_q != '0;

`ifdef AES_STREAM_CTRL_PERF_EN
   logic [31:0] perf_blocks_q, perf_blocks_d, perf_stall_q, perf_stall_d;
   logic [15:0] perf_keys_q, perf_keys_d;

   always_comb begin
      perf_blocks_d = perf_blocks_q + 32'(pop);
      perf_stall_d  = perf_stall_q + 32'((req0_valid || req1_valid) && !(g0 || g1));
      perf_keys_d   = perf_keys_q + 16'(kload);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_blocks_q <= '0;
         perf_stall_q  <= '0;
         perf_keys_q   <= '0;
      end else begin
         perf_blocks_q <= perf_blocks_d;
         perf_stall_q  <= perf_stall_d;
         perf_keys_q   <= perf_keys_d;
      end
   end

   assign perf_blocks = perf_blocks_q;
   assign perf_stall  = perf_stall_q;
   assign perf_keys   = perf_keys_q;
`endif
endmodule
